// File: rtl/mult_arbiter.sv
// Round-robin front end that lets NUM_REQ requesters share one pipelined multiplier.
// Each requester has at most one operation in flight and keeps its own response slot.
module mult_arbiter #(
  parameter int DATA_LEN     = 32,
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_a,
  input  logic [NUM_REQ*DATA_LEN-1:0]  req_b,
  output logic [DATA_LEN-1:0]          mult_a,
  output logic [DATA_LEN-1:0]          mult_b,
  input  logic [DATA_LEN-1:0]          mult_result,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [NUM_REQ*DATA_LEN-1:0]  rsp_data,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic                         busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 outstanding_q, outstanding_d;
  logic [NUM_REQ-1:0]                 rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0]                 eligible, grant, rsp_fire;
  logic [PTR_W-1:0]                   ptr_q, ptr_d, grant_idx;
  logic                               grant_any;
  logic [DATA_LEN-1:0]                mult_a_q, mult_a_d, mult_b_q, mult_b_d;
  logic [NUM_REQ*DATA_LEN-1:0]        rsp_data_q, rsp_data_d;
  logic [MULT_LATENCY:0]              tag_valid_q, tag_valid_d;
  logic [MULT_LATENCY:0][PTR_W-1:0]   tag_idx_q, tag_idx_d;

  assign eligible = req_valid & ~outstanding_q;

  // Search starts at the pointer and wraps; nothing is granted while reset is high.
  always_comb begin
    int slot;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    slot      = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      slot = int'(ptr_q) + off;
      if (slot >= NUM_REQ) slot = slot - NUM_REQ;
      if (!grant_any && !reset && eligible[PTR_W'(slot)]) begin
        grant[PTR_W'(slot)] = 1'b1;
        grant_idx           = PTR_W'(slot);
        grant_any           = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    mult_a_d = mult_a_q;
    mult_b_d = mult_b_q;
    if (grant_any) begin
      ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          mult_a_d = req_a[i*DATA_LEN +: DATA_LEN];
          mult_b_d = req_b[i*DATA_LEN +: DATA_LEN];
        end
      end
    end
  end

  // Tag stage j is visible j+1 cycles after the handshake; the last stage lines up with mult_result.
  always_comb begin
    tag_valid_d    = '0;
    tag_idx_d      = '0;
    tag_valid_d[0] = grant_any;
    tag_idx_d[0]   = grant_idx;
    for (int j = 1; j <= MULT_LATENCY; j++) begin
      tag_valid_d[j] = tag_valid_q[j-1];
      tag_idx_d[j]   = tag_idx_q[j-1];
    end
  end

  always_comb begin
    rsp_fire      = rsp_valid_q & rsp_ready;
    outstanding_d = (outstanding_q | grant) & ~rsp_fire;
    rsp_valid_d   = rsp_valid_q & ~rsp_fire;
    rsp_data_d    = rsp_data_q;
    if (tag_valid_q[MULT_LATENCY]) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tag_idx_q[MULT_LATENCY] == PTR_W'(i)) begin
          rsp_valid_d[i]                         = 1'b1;
          rsp_data_d[i*DATA_LEN +: DATA_LEN]     = mult_result;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding_q <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      ptr_q         <= '0;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
      tag_valid_q   <= '0;
      tag_idx_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      ptr_q         <= ptr_d;
      mult_a_q      <= mult_a_d;
      mult_b_q      <= mult_b_d;
      tag_valid_q   <= tag_valid_d;
      tag_idx_q     <= tag_idx_d;
    end
  end

  assign req_ready = grant;
  assign mult_a    = mult_a_q;
  assign mult_b    = mult_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = |outstanding_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural 3-stage multiplier on the shared port.
// Cycle 0 of each scenario is the cycle whose inputs are driven right after the first tick.
module tb_mult_arbiter;

  localparam int DL = 32;
  localparam int NR = 4;
  localparam int ML = 3;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*DL-1:0]  req_a, req_b, rsp_data;
  logic [DL-1:0]     mult_a, mult_b, mult_result;
  logic              busy;
  logic [DL-1:0]     mpipe [ML];
  int                errors;
  int                checks;

  mult_arbiter #(.DATA_LEN(DL), .NUM_REQ(NR), .MULT_LATENCY(ML)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_result(mult_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Shared multiplier: samples mult_a/mult_b and shows the product ML cycles later.
  always @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < ML; j++) mpipe[j] <= '0;
    end else begin
      mpipe[0] <= mult_a * mult_b;
      for (int j = 1; j < ML; j++) mpipe[j] <= mpipe[j-1];
    end
  end
  assign mult_result = mpipe[ML-1];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [DL-1:0] a, input logic [DL-1:0] b);
    req_a[i*DL +: DL] = a;
    req_b[i*DL +: DL] = b;
  endtask

  task automatic do_reset();
    tick();
    reset = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b1; req_valid = 4'b1111; rsp_ready = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ready_during: got %b expected 0000", req_ready); end
    tick();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_state: got rsp_valid=%b busy=%b ready=%b expected 0000/0/0000", rsp_valid, busy, req_ready);
    end
    checks++;
    if (mult_a !== '0 || mult_b !== '0 || rsp_data !== '0) begin
      errors++; $display("[TB] FAIL reset_regs: got a=%h b=%h data=%h expected zeros", mult_a, mult_b, rsp_data);
    end
    tick();
    reset = 1'b0; req_valid = 4'b1110;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL reset_first_grant: got %b expected 0010", req_ready); end
  endtask

  task automatic test_single_op();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      tick();
      case (c)
        0: begin req_valid = 4'b0001; set_op(0, 32'd7, 32'hFFFF_FFFD); end
        1: req_valid = 4'b0000;
        7: rsp_ready = 4'b0001;
        8: rsp_ready = 4'b0000;
        default: ;
      endcase
      @(negedge clk);
      if (c == 0) begin
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL single_grant: got %b expected 0001", req_ready); end
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (mult_a !== 32'd7 || mult_b !== 32'hFFFF_FFFD) begin
          errors++; $display("[TB] FAIL single_operands_c%0d: got %h/%h expected 00000007/fffffffd", c, mult_a, mult_b);
        end
      end
      if (c == 4) begin
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin errors++; $display("[TB] FAIL single_early: got valid=%b busy=%b expected 0000/1", rsp_valid, busy); end
      end
      if (c == 5 || c == 6) begin
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data[31:0] !== 32'hFFFF_FFEB) begin
          errors++; $display("[TB] FAIL single_rsp_c%0d: got valid=%b data=%h expected 0001/ffffffeb", c, rsp_valid, rsp_data[31:0]);
        end
      end
      if (c == 8) begin
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL single_done: got valid=%b busy=%b expected 0000/0", rsp_valid, busy); end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [DL-1:0] exp_p [NR];
    logic [NR-1:0] exp_r;
    exp_p = '{32'd20, 32'd33, 32'd48, 32'd65};
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      tick();
      if (c == 0) begin
        req_valid = 4'b1111; rsp_ready = 4'b1111;
        for (int i = 0; i < NR; i++) set_op(i, DL'(i + 2), DL'(i + 10));
      end
      if (c == 5) req_valid = 4'b0000;
      @(negedge clk);
      if (c <= 4) begin
        exp_r = (c < 4) ? 4'(1 << c) : 4'b0000;
        checks++;
        if (req_ready !== exp_r) begin errors++; $display("[TB] FAIL rr_grant_c%0d: got %b expected %b", c, req_ready, exp_r); end
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (mult_a !== DL'(c + 1) || mult_b !== DL'(c + 9)) begin
          errors++; $display("[TB] FAIL rr_operands_c%0d: got %0d/%0d expected %0d/%0d", c, mult_a, mult_b, c + 1, c + 9);
        end
      end
      if (c >= 5 && c <= 8) begin
        checks++;
        if (rsp_valid !== 4'(1 << (c - 5)) || rsp_data[(c-5)*DL +: DL] !== exp_p[c-5]) begin
          errors++; $display("[TB] FAIL rr_rsp_c%0d: got valid=%b data=%0d expected %b/%0d", c, rsp_valid, rsp_data[(c-5)*DL +: DL], 4'(1 << (c - 5)), exp_p[c-5]);
        end
      end
      if (c == 9) begin
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle: got valid=%b busy=%b expected 0000/0", rsp_valid, busy); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [NR-1:0] exp_r [12];
    exp_r = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0000, 4'b0000,
              4'b0000, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0100};
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      tick();
      case (c)
        0: begin
          rsp_ready = 4'b1011; req_valid = 4'b0100;
          set_op(0, 32'd2, 32'd3); set_op(1, 32'd4, 32'd5);
          set_op(2, 32'd6, 32'd7); set_op(3, 32'd8, 32'd9);
        end
        1:  req_valid = 4'b1111;
        9:  req_valid = 4'b0100;
        10: rsp_ready = 4'b1111;
        11: rsp_ready = 4'b1011;
        default: ;
      endcase
      @(negedge clk);
      checks++;
      if (req_ready !== exp_r[c]) begin errors++; $display("[TB] FAIL bp_grant_c%0d: got %b expected %b", c, req_ready, exp_r[c]); end
      if (c == 5 || c == 9 || c == 10) begin
        checks++;
        if (rsp_valid[2] !== 1'b1 || rsp_data[2*DL +: DL] !== 32'd42) begin
          errors++; $display("[TB] FAIL bp_hold_c%0d: got valid=%b data=%0d expected 1/42", c, rsp_valid[2], rsp_data[2*DL +: DL]);
        end
      end
      if (c == 11) begin
        checks++;
        if (rsp_valid[2] !== 1'b0) begin errors++; $display("[TB] FAIL bp_release: got valid=%b expected 0", rsp_valid[2]); end
      end
    end
  endtask

  task automatic test_truncation();
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      tick();
      if (c == 0) begin
        rsp_ready = 4'b1111; req_valid = 4'b0001;
        set_op(0, 32'h0001_0000, 32'h0001_0000);
        set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      end
      if (c == 1) req_valid = 4'b0010;
      if (c == 2) req_valid = 4'b0000;
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (req_ready !== 4'b0010) begin errors++; $display("[TB] FAIL trunc_grant1: got %b expected 0010", req_ready); end
      end
      if (c == 2) begin
        checks++;
        if (mult_a !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL trunc_operand: got %h expected ffffffff", mult_a); end
      end
      if (c == 5) begin
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data[31:0] !== 32'd0) begin
          errors++; $display("[TB] FAIL trunc_zero: got valid=%b data=%h expected 0001/00000000", rsp_valid, rsp_data[31:0]);
        end
      end
      if (c == 6) begin
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_data[63:32] !== 32'd1) begin
          errors++; $display("[TB] FAIL trunc_neg: got valid=%b data=%h expected 0010/00000001", rsp_valid, rsp_data[63:32]);
        end
      end
      if (c == 7) begin
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL trunc_idle: got busy=%b expected 0", busy); end
      end
    end
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      tick();
      case (c)
        0: begin rsp_ready = 4'b1111; req_valid = 4'b0001; set_op(0, 32'd3, 32'd4); set_op(1, 32'd5, 32'd6); end
        1: req_valid = 4'b0010;
        2: req_valid = 4'b0000;
        3: begin reset = 1'b1; req_valid = 4'b1111; end
        4: begin reset = 1'b0; req_valid = 4'b0000; end
        10: req_valid = 4'b1111;
        default: ;
      endcase
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rif_busy: got %b expected 1", busy); end
      end
      if (c == 3) begin
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("[TB] FAIL rif_ready_in_reset: got %b expected 0000", req_ready); end
      end
      if (c >= 4 && c <= 9) begin
        checks++;
        if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
          errors++; $display("[TB] FAIL rif_discard_c%0d: got valid=%b busy=%b expected 0000/0", c, rsp_valid, busy);
        end
      end
      if (c == 4) begin
        checks++;
        if (mult_a !== '0 || mult_b !== '0) begin errors++; $display("[TB] FAIL rif_mult_clear: got %h/%h expected 0/0", mult_a, mult_b); end
      end
      if (c == 10) begin
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("[TB] FAIL rif_first_grant: got %b expected 0001", req_ready); end
      end
    end
  endtask

  task automatic test_random();
    logic [NR-1:0] m_out, exp_g;
    logic [DL-1:0] m_exp [NR];
    logic [1:0]    m_ptr, idx, k;
    logic          found;
    do_reset();
    m_out = '0; m_ptr = '0;
    for (int i = 0; i < NR; i++) m_exp[i] = '0;
    for (int cyc = 0; cyc < 10020; cyc++) begin
      tick();
      if (cyc < 10000) begin
        req_valid = 4'($urandom);
        rsp_ready = 4'($urandom);
        for (int i = 0; i < NR; i++) set_op(i, $urandom, $urandom);
      end else begin
        req_valid = 4'b0000;
        rsp_ready = 4'b1111;
      end
      @(negedge clk);
      exp_g = '0; found = 1'b0; k = '0;
      for (int off = 0; off < NR; off++) begin
        idx = m_ptr + 2'(off);
        if (!found && req_valid[idx] && !m_out[idx]) begin found = 1'b1; k = idx; end
      end
      if (found) exp_g[k] = 1'b1;
      checks++;
      if (req_ready !== exp_g) begin errors++; $display("[TB] FAIL rand_grant_%0d: got %b expected %b", cyc, req_ready, exp_g); end
      checks++;
      if (busy !== (|m_out)) begin errors++; $display("[TB] FAIL rand_busy_%0d: got %b expected %b", cyc, busy, |m_out); end
      for (int i = 0; i < NR; i++) begin
        if (rsp_valid[i]) begin
          checks++;
          if (!m_out[i] || rsp_data[i*DL +: DL] !== m_exp[i]) begin
            errors++; $display("[TB] FAIL rand_rsp%0d_%0d: got %h pending=%b expected %h", i, cyc, rsp_data[i*DL +: DL], m_out[i], m_exp[i]);
          end
          if (rsp_ready[i]) m_out[i] = 1'b0;
        end
      end
      if (found) begin
        m_out[k] = 1'b1;
        m_exp[k] = req_a[k*DL +: DL] * req_b[k*DL +: DL];
        m_ptr    = k + 2'd1;
      end
    end
    checks++;
    if (m_out !== 4'b0000) begin errors++; $display("[TB] FAIL rand_drain: got pending=%b expected 0000", m_out); end
  endtask

  initial begin
    errors = 0; checks = 0;
    reset = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single_op();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_reset_in_flight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
